// File: rtl/sar_search_pkg.sv
// Shared types for comparator-driven search blocks.
// No logic of its own; decode is purely combinational.
// No flow control.
package sar_search_pkg;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TEST = 2'd1,
    DONE = 2'd2
  } state_t;

  // Comparator verdict after priority resolution
  typedef enum logic [1:0] {
    RES_EQ = 2'd0,
    RES_GT = 2'd1,
    RES_LT = 2'd2
  } cmp_res_t;

  // eq wins over gt, gt over lt; no flag asserted is read as lt so a
  // silent comparator keeps every bit instead of stalling the search.
  function automatic cmp_res_t decode_cmp(input logic eq, input logic gt, input logic lt);
    cmp_res_t r;
    if (eq)      r = RES_EQ;
    else if (gt) r = RES_GT;
    else         r = RES_LT;
    // lt is implied by the fall-through; kept as an argument so every
    // consumer passes the full comparator triple.
    if (lt && !eq && !gt) r = RES_LT;
    return r;
  endfunction

endpackage

// File: rtl/mag_cmp.sv
// Combinational magnitude comparator: eq/gt/lt of a against b.
// Zero latency.
// No flow control.
module mag_cmp #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  // Exactly one flag is asserted for any pair of operands
  always_comb begin
    eq = (a == b);
    gt = (a > b);
    lt = (a < b);
  end

endmodule

// File: rtl/sar_search.sv
// MSB-first successive-approximation search against an external comparator.
// Latency: start at edge k -> done in cycle k+m+1, m = bits tested (1..WIDTH).
// No backpressure: start is only honoured in IDLE; extra starts are dropped.
module sar_search
  import sar_search_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cmp_eq,
  input  logic             cmp_gt,
  input  logic             cmp_lt,
  output logic [WIDTH-1:0] trial,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             found_exact
);

  localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDXW-1:0]  IDX_TOP = IDXW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] TOP_BIT = WIDTH'(1) << (WIDTH - 1);

  state_t           state, state_nxt;
  logic [IDXW-1:0]  idx;
  logic [IDXW-1:0]  idx_m1;
  cmp_res_t         res;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] work_set;

  assign res    = decode_cmp(cmp_eq, cmp_gt, cmp_lt);
  assign idx_m1 = idx - IDXW'(1);

  // Working code for this step: drop the bit under test if trial overshot,
  // and pre-compute the next trial with the following lower bit set.
  always_comb begin
    work     = trial;
    work_set = '0;
    if (res == RES_GT) work[idx] = 1'b0;
    work_set = work;
    if (idx != '0) work_set[idx_m1] = 1'b1;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: TEST ends on an exact hit or after the LSB
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = TEST;
      TEST:    if (res == RES_EQ || idx == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; busy and done are mutually exclusive
  always_comb begin
    busy = (state == TEST);
    done = (state == DONE);
  end

  // Search datapath: trial/idx advance in TEST, result latched on exit
  always_ff @(posedge clk) begin
    if (rst) begin
      trial       <= '0;
      idx         <= IDX_TOP;
      result      <= '0;
      found_exact <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            trial       <= TOP_BIT;
            idx         <= IDX_TOP;
            found_exact <= 1'b0;
          end
        end
        TEST: begin
          if (res == RES_EQ) begin
            result      <= trial;
            found_exact <= 1'b1;
          end else if (idx == '0) begin
            result      <= work;
            found_exact <= 1'b0;
          end else begin
            trial <= work_set;
            idx   <= idx_m1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_search.sv
module tb_sar_search;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] target;
  logic       none_mode;
  logic       c_eq, c_gt, c_lt;
  logic       cmp_eq, cmp_gt, cmp_lt;
  logic [3:0] trial;
  logic       busy, done;
  logic [3:0] result;
  logic       found_exact;

  int tests = 0;
  int fails = 0;

  // Observations from the most recent search
  logic [3:0] obs_trials [8];
  int         obs_n;
  int         obs_done_cyc;
  int         obs_overlap;
  logic [3:0] obs_res;
  logic       obs_fe;
  logic [3:0] obs_res_c1;
  logic       obs_fe_c1;

  always #5 clk = ~clk;

  mag_cmp #(.WIDTH(4)) u_cmp (
    .a (trial),
    .b (target),
    .eq(c_eq),
    .gt(c_gt),
    .lt(c_lt)
  );

  assign cmp_eq = none_mode ? 1'b0 : c_eq;
  assign cmp_gt = none_mode ? 1'b0 : c_gt;
  assign cmp_lt = none_mode ? 1'b0 : c_lt;

  sar_search #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cmp_eq     (cmp_eq),
    .cmp_gt     (cmp_gt),
    .cmp_lt     (cmp_lt),
    .trial      (trial),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .found_exact(found_exact)
  );

  // Pulse start for one edge, then watch cycles k+1.. until done (bounded).
  // repulse_cyc > 0 re-asserts start for one edge during that cycle.
  task automatic run_search(input logic [3:0] tgt, input logic none, input int repulse_cyc);
    @(negedge clk);
    target    = tgt;
    none_mode = none;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    obs_n = 0; obs_done_cyc = -1; obs_overlap = 0;
    obs_res = 'x; obs_fe = 1'bx;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin obs_res_c1 = result; obs_fe_c1 = found_exact; end
      if (busy && done) obs_overlap = 1;
      if (busy && obs_n < 8) begin obs_trials[obs_n] = trial; obs_n++; end
      start = (cyc == repulse_cyc);
      if (done) begin
        obs_done_cyc = cyc;
        obs_res = result;
        obs_fe  = found_exact;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; target = 4'd0; none_mode = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++; if (trial !== 4'd0) begin fails++; $display("FAIL reset_trial: got %0d expected 0", trial); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
    tests++; if (result !== 4'd0) begin fails++; $display("FAIL reset_result: got %0d expected 0", result); end
    tests++; if (found_exact !== 1'b0) begin fails++; $display("FAIL reset_fe: got %b expected 0", found_exact); end
    rst = 1'b0;
  endtask

  // Generic check of one finished search against hand-computed values
  task automatic check_search(input string name, input int exp_n, input logic [3:0] e0,
                              input logic [3:0] e1, input logic [3:0] e2, input logic [3:0] e3,
                              input int exp_done, input logic [3:0] exp_res, input logic exp_fe);
    logic [3:0] exp_tr [4];
    exp_tr[0] = e0; exp_tr[1] = e1; exp_tr[2] = e2; exp_tr[3] = e3;
    tests++; if (obs_n !== exp_n) begin fails++; $display("FAIL %s_busy_cycles: got %0d expected %0d", name, obs_n, exp_n); end
    for (int i = 0; i < exp_n && i < obs_n; i++) begin
      tests++;
      if (obs_trials[i] !== exp_tr[i]) begin
        fails++; $display("FAIL %s_trial%0d: got %0d expected %0d", name, i, obs_trials[i], exp_tr[i]);
      end
    end
    tests++; if (obs_done_cyc !== exp_done) begin fails++; $display("FAIL %s_done_cycle: got %0d expected %0d", name, obs_done_cyc, exp_done); end
    tests++; if (obs_res !== exp_res) begin fails++; $display("FAIL %s_result: got %0d expected %0d", name, obs_res, exp_res); end
    tests++; if (obs_fe !== exp_fe) begin fails++; $display("FAIL %s_found_exact: got %b expected %b", name, obs_fe, exp_fe); end
    tests++; if (obs_overlap !== 0) begin fails++; $display("FAIL %s_busy_done_overlap: got %0d expected 0", name, obs_overlap); end
  endtask

  task automatic test_target9();
    run_search(4'd9, 1'b0, 0);
    check_search("t9", 4, 4'd8, 4'd12, 4'd10, 4'd9, 5, 4'd9, 1'b1);
  endtask

  task automatic test_early_exit();
    run_search(4'd8, 1'b0, 0);
    check_search("t8", 1, 4'd8, 4'd0, 4'd0, 4'd0, 2, 4'd8, 1'b1);
    // Previous result (9) holds while the new search runs
    tests++; if (obs_res_c1 !== 4'd9) begin fails++; $display("FAIL t8_result_hold: got %0d expected 9", obs_res_c1); end
  endtask

  task automatic test_target0();
    run_search(4'd0, 1'b0, 0);
    check_search("t0", 4, 4'd8, 4'd4, 4'd2, 4'd1, 5, 4'd0, 1'b0);
  endtask

  task automatic test_back_to_back();
    // Started in the IDLE cycle right after the previous DONE
    run_search(4'd15, 1'b0, 0);
    check_search("t15", 4, 4'd8, 4'd12, 4'd14, 4'd15, 5, 4'd15, 1'b1);
  endtask

  task automatic test_none_asserted();
    run_search(4'd3, 1'b1, 0);
    check_search("none", 4, 4'd8, 4'd12, 4'd14, 4'd15, 5, 4'd15, 1'b0);
    tests++; if (obs_fe_c1 !== 1'b0) begin fails++; $display("FAIL none_fe_cleared: got %b expected 0", obs_fe_c1); end
    none_mode = 1'b0;
  endtask

  task automatic test_start_ignored();
    int late_busy;
    run_search(4'd9, 1'b0, 2);
    check_search("repulse", 4, 4'd8, 4'd12, 4'd10, 4'd9, 5, 4'd9, 1'b1);
    late_busy = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (busy || done) late_busy++;
    end
    tests++; if (late_busy !== 0) begin fails++; $display("FAIL repulse_no_restart: got %0d active cycles expected 0", late_busy); end
  endtask

  task automatic test_abort_and_fresh();
    int done_seen;
    @(negedge clk);
    target = 4'd9; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);   // cycle k+1, first TEST
    @(negedge clk);   // cycle k+2, second TEST
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL abort_busy_before: got %b expected 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++; if (trial !== 4'd0) begin fails++; $display("FAIL abort_trial: got %0d expected 0", trial); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b expected 0", busy); end
    tests++; if (result !== 4'd0) begin fails++; $display("FAIL abort_result: got %0d expected 0", result); end
    tests++; if (found_exact !== 1'b0) begin fails++; $display("FAIL abort_fe: got %b expected 0", found_exact); end
    done_seen = (done === 1'b1) ? 1 : 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done !== 1'b0) done_seen++;
    end
    tests++; if (done_seen !== 0) begin fails++; $display("FAIL abort_no_done: got %0d done cycles expected 0", done_seen); end
    run_search(4'd5, 1'b0, 0);
    check_search("t5", 4, 4'd8, 4'd4, 4'd6, 4'd5, 5, 4'd5, 1'b1);
  endtask

  initial begin
    test_reset();
    test_target9();
    test_early_exit();
    test_target0();
    test_back_to_back();
    test_none_asserted();
    test_start_ignored();
    test_abort_and_fresh();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
